// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(7,4) decode arbiter.
package hamming_pkg;

  localparam int unsigned CW_W   = 7;
  localparam int unsigned DATA_W = 4;

  localparam logic [2:0] SYN_NONE = 3'd0;
  localparam logic [2:0] SYN_C2   = 3'd3;
  localparam logic [2:0] SYN_C4   = 3'd5;
  localparam logic [2:0] SYN_C5   = 3'd6;
  localparam logic [2:0] SYN_C6   = 3'd7;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } slot_state_e;

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) syndrome and single-error correction.
module hamming74_correct
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   cw,
  output logic [2:0]        syn,
  output logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] data,
  output logic              corr
);

  always_comb begin
    syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    raw    = {cw[6], cw[5], cw[4], cw[2]};
    data   = raw;
    // Parity-bit syndromes (1, 2, 4) leave the data field untouched.
    case (syn)
      SYN_C2:  data[0] = ~raw[0];
      SYN_C4:  data[1] = ~raw[1];
      SYN_C5:  data[2] = ~raw[2];
      SYN_C6:  data[3] = ~raw[3];
      default: ;
    endcase
    corr = (syn != SYN_NONE);
  end

endmodule

// File: rtl/hamming_dec_arbiter.sv
// Round-robin arbiter sharing one Hamming(7,4) decoder, with a registered response slot
// and a saturating correction counter.
module hamming_dec_arbiter
  import hamming_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*CW_W-1:0] req_cw,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [DATA_W-1:0]       rsp_raw,
  output logic [2:0]              rsp_syn,
  output logic                    rsp_corr,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        corr_cnt
);

  localparam logic [ID_W-1:0]  RrInit = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  slot_state_e       state_q, state_d;
  logic [ID_W-1:0]   rr_last_q;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_found;
  logic [CW_W-1:0]   gnt_cw;
  logic              can_accept;
  logic              xfer;
  logic              handoff;
  int unsigned       rr_int;

  logic [2:0]        dec_syn;
  logic [DATA_W-1:0] dec_raw, dec_data;
  logic              dec_corr;

  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q, rsp_raw_q;
  logic [2:0]        rsp_syn_q;
  logic              rsp_corr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Grant search: channels above rr_last first, then wrap to 0..rr_last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_cw    = '0;
    rr_int    = 32'(rr_last_q);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (i > rr_int)) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
        gnt_cw    = req_cw[i*CW_W +: CW_W];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (i <= rr_int)) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
        gnt_cw    = req_cw[i*CW_W +: CW_W];
      end
    end
  end

  assign can_accept = (state_q == ST_EMPTY) | rsp_ready;
  assign xfer       = gnt_found & can_accept;
  assign handoff    = (state_q == ST_FULL) & rsp_ready;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (gnt_idx == ID_W'(i));
    end
  end

  hamming74_correct u_correct (
    .cw   (gnt_cw),
    .syn  (dec_syn),
    .raw  (dec_raw),
    .data (dec_data),
    .corr (dec_corr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (!xfer && rsp_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Clear takes priority over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (handoff && rsp_corr_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      rr_last_q  <= RrInit;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_raw_q  <= '0;
      rsp_syn_q  <= '0;
      rsp_corr_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (xfer) begin
        rr_last_q  <= gnt_idx;
        rsp_id_q   <= gnt_idx;
        rsp_data_q <= dec_data;
        rsp_raw_q  <= dec_raw;
        rsp_syn_q  <= dec_syn;
        rsp_corr_q <= dec_corr;
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_raw   = rsp_raw_q;
  assign rsp_syn   = rsp_syn_q;
  assign rsp_corr  = rsp_corr_q;
  assign corr_cnt  = cnt_q;

endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// Self-checking bench: behavioural model checked every cycle plus directed literal checks.
module tb_hamming_dec_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [13:0] req_cw;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic [3:0]  rsp_raw;
  logic [2:0]  rsp_syn;
  logic        rsp_corr;
  logic        cnt_clr;
  logic [7:0]  corr_cnt;

  int n_pass  = 0;
  int n_total = 0;
  logic cmp_en = 1'b0;

  hamming_dec_arbiter #(
    .NUM_REQ (2),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cw    (req_cw),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_raw   (rsp_raw),
    .rsp_syn   (rsp_syn),
    .rsp_corr  (rsp_corr),
    .cnt_clr   (cnt_clr),
    .corr_cnt  (corr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Model decode: syndrome is the XOR of the 1-based positions of all set bits.
  // Returns {syn[2:0], corr, raw[3:0], data[3:0]}.
  function automatic logic [11:0] model_dec(input logic [6:0] cw);
    int s = 0;
    logic [6:0] c = cw;
    for (int i = 0; i < 7; i++) if (cw[i]) s = s ^ (i + 1);
    if (s != 0) c[s-1] = ~c[s-1];
    return {s[2:0], (s != 0), cw[6], cw[5], cw[4], cw[2], c[6], c[5], c[4], c[2]};
  endfunction

  function automatic int model_grant(input logic [1:0] v, input int rr);
    for (int k = 1; k <= 2; k++) begin
      if (v[(rr + k) % 2]) return (rr + k) % 2;
    end
    return -1;
  endfunction

  logic       m_valid;
  logic [6:0] m_cw;
  int         m_id, m_rr, m_cnt, m_g;
  logic       m_acc;
  logic [11:0] m_dec;
  logic [1:0] m_rdy;

  always_comb begin
    m_g   = model_grant(req_valid, m_rr);
    m_acc = !m_valid || rsp_ready;
    m_dec = model_dec(m_cw);
    m_rdy = (m_g >= 0 && m_acc) ? (2'b01 << m_g) : 2'b00;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_cw    <= '0;
      m_id    <= 0;
      m_rr    <= 1;
      m_cnt   <= 0;
    end else begin
      if (cnt_clr) m_cnt <= 0;
      else if (m_valid && rsp_ready && m_dec[8] && m_cnt < 255) m_cnt <= m_cnt + 1;
      if (m_g >= 0 && m_acc) begin
        m_valid <= 1'b1;
        m_cw    <= req_cw[m_g*7 +: 7];
        m_id    <= m_g;
        m_rr    <= m_g;
      end else if (m_valid && rsp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("req_ready", 32'(req_ready), 32'(m_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_syn", 32'(rsp_syn), 32'(m_dec[11:9]));
        check("rsp_corr", 32'(rsp_corr), 32'(m_dec[8]));
        check("rsp_raw", 32'(rsp_raw), 32'(m_dec[7:4]));
        check("rsp_data", 32'(rsp_data), 32'(m_dec[3:0]));
      end
      check("corr_cnt", 32'(corr_cnt), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_cw = '0; rsp_ready = 1'b0; cnt_clr = 1'b0;
    #3;
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset rsp_id", 32'(rsp_id), 0);
    check("reset rsp_data", 32'(rsp_data), 0);
    check("reset rsp_raw", 32'(rsp_raw), 0);
    check("reset rsp_syn", 32'(rsp_syn), 0);
    check("reset rsp_corr", 32'(rsp_corr), 0);
    check("reset corr_cnt", 32'(corr_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Clean word on ch0
    req_cw[6:0] = 7'h55; req_valid = 2'b01; rsp_ready = 1'b1;
    tick(); req_valid = 2'b00;
    @(negedge clk);
    check("clean valid", 32'(rsp_valid), 1);
    check("clean id", 32'(rsp_id), 0);
    check("clean data", 32'(rsp_data), 32'hB);
    check("clean syn", 32'(rsp_syn), 0);
    check("clean corr", 32'(rsp_corr), 0);
    check("clean cnt", 32'(corr_cnt), 0);
    tick();

    // c4 flipped on ch1
    req_cw[13:7] = 7'h45; req_valid = 2'b10;
    tick(); req_valid = 2'b00;
    @(negedge clk);
    check("err id", 32'(rsp_id), 1);
    check("err syn", 32'(rsp_syn), 5);
    check("err raw", 32'(rsp_raw), 32'h9);
    check("err data", 32'(rsp_data), 32'hB);
    check("err corr", 32'(rsp_corr), 1);
    tick();
    @(negedge clk);
    check("err cnt", 32'(corr_cnt), 1);

    // Round-robin with both channels valid
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("rr valid", 32'(rsp_valid), 1);
      check("rr id", 32'(rsp_id), 32'(i % 2));
      check("rr onehot", 32'($countones(req_ready) <= 1), 1);
    end

    // Backpressure: slot holds the ch1 word
    rsp_ready = 1'b0; req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("bp ready", 32'(req_ready), 0);
      check("bp valid", 32'(rsp_valid), 1);
      check("bp id", 32'(rsp_id), 1);
      check("bp syn", 32'(rsp_syn), 5);
    end
    req_cw[6:0] = 7'h00; rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp drain valid", 32'(rsp_valid), 1);
    check("bp drain id", 32'(rsp_id), 0);
    check("bp drain data", 32'(rsp_data), 0);
    req_valid = 2'b00;
    tick();

    // Saturation
    req_valid = 2'b10; req_cw[13:7] = 7'h45;
    repeat (300) tick();
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    check("sat cnt", 32'(corr_cnt), 255);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr cnt", 32'(corr_cnt), 0);
    check("clr valid", 32'(rsp_valid), 0);

    // Async reset while FULL
    req_valid = 2'b10;
    tick(); tick();
    req_valid = 2'b00; rsp_ready = 1'b0;
    @(negedge clk);
    check("pre-rst cnt", 32'(corr_cnt), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst valid", 32'(rsp_valid), 0);
    check("arst cnt", 32'(corr_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;
    req_valid = 2'b11; rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("post-rst valid", 32'(rsp_valid), 1);
    check("post-rst id", 32'(rsp_id), 0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
